// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes three bouncy push buttons and two switch
// banks, debounces each button with its own FSM, and turns accepted presses
// into one-cycle pulses. The change button also auto-repeats while held.
// The digit switches are held steady around each digit_load pulse, so the
// digit that gets loaded is the one shown just before the pulse.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 16,
   parameter int REPEAT_CYCLES   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_raw,
   input  logic       change_raw,
   input  logic       mode_raw,
   input  logic [6:0] digit_choice_raw,
   input  logic [1:0] device_choice_raw,
   output logic       digit_load,
   output logic       digit_change,
   output logic       mode_change,
   output logic [6:0] digit_choice,
   output logic [1:0] device_choice,
   // Debug view of the button FSM states: [1:0] load, [3:2] change, [5:4] mode.
   output logic [5:0] dbg_state
);

   // Button index map used by every per-button array below.
   localparam int BTN_LOAD   = 0;
   localparam int BTN_CHANGE = 1;
   localparam int NB         = 3;

   localparam logic [15:0] DEB_LIM  = 16'(DEBOUNCE_CYCLES);
   localparam logic [15:0] HOLD_LIM = 16'(HOLD_CYCLES);
   localparam logic [15:0] REP_LIM  = 16'(REPEAT_CYCLES);
   localparam logic [15:0] CNT_MAX  = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } btn_state_t;

   // Handshake note: there is no valid/ready flow here. Every output pulse
   // is a single-cycle strobe that the consumer must sample on the cycle it
   // is high; nothing is held or retried.

   logic [NB-1:0] w_btn_raw;
   logic [NB-1:0] r_btn_meta;
   logic [NB-1:0] r_btn_sync;
   logic [6:0]    r_digit_meta;
   logic [6:0]    r_digit_sync;
   logic [1:0]    r_dev_meta;
   logic [1:0]    r_dev_sync;

   btn_state_t    r_state [NB];
   logic [15:0]   r_cnt   [NB];
   logic [NB-1:0] r_evt;
   logic [NB-1:0] r_pulse;
   logic [NB-1:0] w_press_done;

   logic [15:0]   r_hold_cnt;
   logic [15:0]   r_rep_cnt;
   logic          r_repeating;
   logic          r_hold_evt;
   logic          w_chg_held;
   logic          w_chg_release_done;
   logic          w_digit_freeze;

   assign w_btn_raw = {mode_raw, change_raw, load_raw};

   // Two-flop synchronizers for the buttons and the device switches.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn_meta <= '0;
         r_btn_sync <= '0;
         r_dev_meta <= '0;
         r_dev_sync <= '0;
      end else begin
         r_btn_meta <= w_btn_raw;
         r_btn_sync <= r_btn_meta;
         r_dev_meta <= device_choice_raw;
         r_dev_sync <= r_dev_meta;
      end
   end

   // Debounce completion: the FSM will enter PRESSED on this edge.
   always_comb begin
      w_press_done = '0;
      for (int i = 0; i < NB; i++) begin
         w_press_done[i] = (r_state[i] == ST_PRESS_WAIT) && r_btn_sync[i] &&
                           (r_cnt[i] == DEB_LIM);
      end
   end

   // The digit switches freeze on the edge that accepts a load press and on
   // the edge that raises digit_load, so the pulse cycle and the cycle before
   // it both show the pre-pulse value.
   assign w_digit_freeze = w_press_done[BTN_LOAD] || r_evt[BTN_LOAD];

   // Digit switch synchronizer; its second flop doubles as the freeze register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_digit_meta <= '0;
         r_digit_sync <= '0;
      end else begin
         r_digit_meta <= digit_choice_raw;
         if (!w_digit_freeze) begin
            r_digit_sync <= r_digit_meta;
         end
      end
   end

   // Per-button debounce FSMs; r_evt marks an accepted press for the pulse stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NB; i++) begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
         end
         r_evt <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            r_evt[i] <= 1'b0;
            case (r_state[i])
               ST_IDLE: begin
                  if (r_btn_sync[i]) begin
                     r_state[i] <= ST_PRESS_WAIT;
                     r_cnt[i]   <= 16'd1;
                  end
               end
               ST_PRESS_WAIT: begin
                  if (!r_btn_sync[i]) begin
                     r_state[i] <= ST_IDLE;
                     r_cnt[i]   <= '0;
                  end else if (r_cnt[i] == DEB_LIM) begin
                     r_state[i] <= ST_PRESSED;
                     r_cnt[i]   <= '0;
                     r_evt[i]   <= 1'b1;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + 16'd1;
                  end
               end
               ST_PRESSED: begin
                  if (!r_btn_sync[i]) begin
                     r_state[i] <= ST_RELEASE_WAIT;
                     r_cnt[i]   <= 16'd1;
                  end
               end
               ST_RELEASE_WAIT: begin
                  // A bounce back to 1 returns to PRESSED without a new pulse.
                  if (r_btn_sync[i]) begin
                     r_state[i] <= ST_PRESSED;
                     r_cnt[i]   <= '0;
                  end else if (r_cnt[i] == DEB_LIM) begin
                     r_state[i] <= ST_IDLE;
                     r_cnt[i]   <= '0;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + 16'd1;
                  end
               end
               default: begin
                  r_state[i] <= ST_IDLE;
                  r_cnt[i]   <= '0;
               end
            endcase
         end
      end
   end

   // Change button counts as held in PRESSED and while bouncing in RELEASE_WAIT.
   assign w_chg_held = (r_state[BTN_CHANGE] == ST_PRESSED) ||
                       (r_state[BTN_CHANGE] == ST_RELEASE_WAIT);

   // Release debounce finishing on this edge: the button is back in IDLE next
   // cycle, so a repeat that would coincide with it is dropped.
   assign w_chg_release_done = (r_state[BTN_CHANGE] == ST_RELEASE_WAIT) &&
                               !r_btn_sync[BTN_CHANGE] &&
                               (r_cnt[BTN_CHANGE] == DEB_LIM);

   // Hold and auto-repeat timing for the change button; both counters saturate.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_cnt  <= '0;
         r_rep_cnt   <= '0;
         r_repeating <= 1'b0;
         r_hold_evt  <= 1'b0;
      end else begin
         r_hold_evt <= 1'b0;
         if (w_press_done[BTN_CHANGE]) begin
            // The accepting edge counts as the first held cycle.
            r_hold_cnt  <= 16'd1;
            r_rep_cnt   <= '0;
            r_repeating <= 1'b0;
         end else if (w_chg_held && !w_chg_release_done) begin
            if (r_hold_cnt != CNT_MAX) begin
               r_hold_cnt <= r_hold_cnt + 16'd1;
            end
            if (!r_repeating) begin
               if (r_hold_cnt == HOLD_LIM) begin
                  r_hold_evt  <= 1'b1;
                  r_repeating <= 1'b1;
                  r_rep_cnt   <= 16'd1;
               end
            end else if (r_rep_cnt == REP_LIM) begin
               r_hold_evt <= 1'b1;
               r_rep_cnt  <= 16'd1;
            end else if (r_rep_cnt != CNT_MAX) begin
               r_rep_cnt <= r_rep_cnt + 16'd1;
            end
         end else begin
            r_hold_cnt  <= '0;
            r_rep_cnt   <= '0;
            r_repeating <= 1'b0;
         end
      end
   end

   // Output pulse register: press events and change-button repeats merge here.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pulse <= '0;
      end else begin
         r_pulse <= r_evt | {1'b0, r_hold_evt, 1'b0};
      end
   end

   assign digit_load    = r_pulse[0];
   assign digit_change  = r_pulse[1];
   assign mode_change   = r_pulse[2];
   assign digit_choice  = r_digit_sync;
   assign device_choice = r_dev_sync;
   assign dbg_state     = {r_state[2], r_state[1], r_state[0]};

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with default parameters. Expected pulse edges
// are queued per output when stimulus is driven; a negedge monitor pops and
// compares whenever the DUT raises a pulse.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_raw;
   logic       change_raw;
   logic       mode_raw;
   logic [6:0] digit_choice_raw;
   logic [1:0] device_choice_raw;
   logic       digit_load;
   logic       digit_change;
   logic       mode_change;
   logic [6:0] digit_choice;
   logic [1:0] device_choice;
   logic [5:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] cyc = '0;

   logic [31:0] exp_load_q[$];
   logic [31:0] exp_change_q[$];
   logic [31:0] exp_mode_q[$];

   button_conditioner dut (
      .clk               (clk),
      .rst               (rst),
      .load_raw          (load_raw),
      .change_raw        (change_raw),
      .mode_raw          (mode_raw),
      .digit_choice_raw  (digit_choice_raw),
      .device_choice_raw (device_choice_raw),
      .digit_load        (digit_load),
      .digit_change      (digit_change),
      .mode_change       (mode_change),
      .digit_choice      (digit_choice),
      .device_choice     (device_choice),
      .dbg_state         (dbg_state)
   );

   // Clock and edge counter; cyc read at a negedge is the number of the last rising edge.
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   // Scoreboard: every pulse seen must match the head of its expected queue.
   always @(negedge clk) begin
      logic [31:0] e;
      if (digit_load) begin
         n_checks++;
         if (exp_load_q.size() == 0) begin
            n_fail++;
            $display("FAIL digit_load_pulse: pulse at edge %0d, required none", cyc);
         end else begin
            e = exp_load_q.pop_front();
            if (cyc !== e) begin
               n_fail++;
               $display("FAIL digit_load_pulse: pulse at edge %0d, required edge %0d", cyc, e);
            end
         end
      end
      if (digit_change) begin
         n_checks++;
         if (exp_change_q.size() == 0) begin
            n_fail++;
            $display("FAIL digit_change_pulse: pulse at edge %0d, required none", cyc);
         end else begin
            e = exp_change_q.pop_front();
            if (cyc !== e) begin
               n_fail++;
               $display("FAIL digit_change_pulse: pulse at edge %0d, required edge %0d", cyc, e);
            end
         end
      end
      if (mode_change) begin
         n_checks++;
         if (exp_mode_q.size() == 0) begin
            n_fail++;
            $display("FAIL mode_change_pulse: pulse at edge %0d, required none", cyc);
         end else begin
            e = exp_mode_q.pop_front();
            if (cyc !== e) begin
               n_fail++;
               $display("FAIL mode_change_pulse: pulse at edge %0d, required edge %0d", cyc, e);
            end
         end
      end
   end

   // Driver: advance n falling edges.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      load_raw = 1'b0; change_raw = 1'b0; mode_raw = 1'b0;
      digit_choice_raw = 7'h55;
      device_choice_raw = 2'b10;
      step(3);
      n_checks++;
      if ({digit_load, digit_change, mode_change} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_pulses: got %b, required 000", {digit_load, digit_change, mode_change});
      end
      n_checks++;
      if (digit_choice !== 7'h00 || device_choice !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_switches: got digit %h device %b, required 00 and 00", digit_choice, device_choice);
      end
      n_checks++;
      if (dbg_state !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %h, required 00", dbg_state);
      end
      rst = 1'b0;
      step(2);
      n_checks++;
      if (digit_choice !== 7'h55 || device_choice !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_release_switches: got digit %h device %b, required 55 and 10", digit_choice, device_choice);
      end
      digit_choice_raw = 7'h00;
      device_choice_raw = 2'b00;
      step(4);
   endtask

   task automatic test_clean_press();
      logic [31:0] c0;
      c0 = cyc;
      load_raw = 1'b1;
      exp_load_q.push_back(c0 + 8);
      step(20);
      load_raw = 1'b0;
      step(20);
      n_checks++;
      if (exp_load_q.size() + exp_change_q.size() + exp_mode_q.size() != 0) begin
         n_fail++;
         $display("FAIL clean_press_pending: %0d pulses missing, required 0",
                  exp_load_q.size() + exp_change_q.size() + exp_mode_q.size());
         exp_load_q.delete(); exp_change_q.delete(); exp_mode_q.delete();
      end
   endtask

   task automatic test_glitch();
      int ch;
      for (int i = 0; i < 8; i++) begin
         mode_raw = (i % 2 == 0);
         step(1);
      end
      mode_raw = 1'b0;
      step(10);
      // Random glitches of 1..3 cycles on random buttons; none may be accepted.
      for (int i = 0; i < 12; i++) begin
         ch = $urandom_range(0, 2);
         case (ch)
            0: load_raw = 1'b1;
            1: change_raw = 1'b1;
            default: mode_raw = 1'b1;
         endcase
         step($urandom_range(1, 3));
         load_raw = 1'b0; change_raw = 1'b0; mode_raw = 1'b0;
         step($urandom_range(1, 4));
      end
      step(10);
      n_checks++;
      if (dbg_state !== 6'd0) begin
         n_fail++;
         $display("FAIL glitch_idle: state %h, required 00", dbg_state);
      end
   endtask

   task automatic test_bounce();
      logic [31:0] c1;
      for (int i = 0; i < 2; i++) begin
         load_raw = 1'b1; step(1);
         load_raw = 1'b0; step(1);
      end
      c1 = cyc;
      load_raw = 1'b1;
      exp_load_q.push_back(c1 + 8);
      step(15);
      load_raw = 1'b0; step(2);
      load_raw = 1'b1; step(5);
      load_raw = 1'b0; step(15);
      n_checks++;
      if (exp_load_q.size() + exp_change_q.size() + exp_mode_q.size() != 0) begin
         n_fail++;
         $display("FAIL bounce_pending: %0d pulses missing, required 0",
                  exp_load_q.size() + exp_change_q.size() + exp_mode_q.size());
         exp_load_q.delete(); exp_change_q.delete(); exp_mode_q.delete();
      end
   endtask

   task automatic test_hold_repeat();
      logic [31:0] c0;
      c0 = cyc;
      change_raw = 1'b1;
      exp_change_q.push_back(c0 + 8);
      exp_change_q.push_back(c0 + 24);
      exp_change_q.push_back(c0 + 32);
      exp_change_q.push_back(c0 + 40);
      step(40);
      change_raw = 1'b0;
      step(25);
      n_checks++;
      if (exp_load_q.size() + exp_change_q.size() + exp_mode_q.size() != 0) begin
         n_fail++;
         $display("FAIL hold_repeat_pending: %0d pulses missing, required 0",
                  exp_load_q.size() + exp_change_q.size() + exp_mode_q.size());
         exp_load_q.delete(); exp_change_q.delete(); exp_mode_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] c0;
      for (int i = 0; i < 3; i++) begin
         c0 = cyc;
         load_raw = 1'b1;
         exp_load_q.push_back(c0 + 8);
         step($urandom_range(8, 14));
         load_raw = 1'b0;
         step($urandom_range(8, 12));
      end
      step(10);
      n_checks++;
      if (exp_load_q.size() + exp_change_q.size() + exp_mode_q.size() != 0) begin
         n_fail++;
         $display("FAIL back_to_back_pending: %0d pulses missing, required 0",
                  exp_load_q.size() + exp_change_q.size() + exp_mode_q.size());
         exp_load_q.delete(); exp_change_q.delete(); exp_mode_q.delete();
      end
   endtask

   task automatic test_switches();
      logic [31:0] c0;
      digit_choice_raw = 7'h41;
      device_choice_raw = 2'b00;
      step(4);
      c0 = cyc;
      load_raw = 1'b1;
      exp_load_q.push_back(c0 + 8);
      step(2);
      digit_choice_raw = 7'h02;
      device_choice_raw = 2'b11;
      step(1);
      n_checks++;
      if (device_choice !== 2'b00) begin
         n_fail++;
         $display("FAIL device_latency_early: got %b after 1 edge, required 00", device_choice);
      end
      step(1);
      n_checks++;
      if (device_choice !== 2'b11) begin
         n_fail++;
         $display("FAIL device_latency: got %b after 2 edges, required 11", device_choice);
      end
      step(1);
      digit_choice_raw = 7'h33;
      step(1);
      n_checks++;
      if (digit_choice !== 7'h02) begin
         n_fail++;
         $display("FAIL digit_track: got %h, required 02", digit_choice);
      end
      step(1);
      n_checks++;
      if (digit_choice !== 7'h02) begin
         n_fail++;
         $display("FAIL digit_freeze_pre: got %h, required 02", digit_choice);
      end
      step(1);
      n_checks++;
      if (digit_choice !== 7'h02 || digit_load !== 1'b1) begin
         n_fail++;
         $display("FAIL digit_freeze_pulse: got digit %h load %b, required 02 and 1", digit_choice, digit_load);
      end
      step(1);
      n_checks++;
      if (digit_choice !== 7'h33) begin
         n_fail++;
         $display("FAIL digit_resume: got %h, required 33", digit_choice);
      end
      step(12);
      load_raw = 1'b0;
      step(15);
      n_checks++;
      if (exp_load_q.size() + exp_change_q.size() + exp_mode_q.size() != 0) begin
         n_fail++;
         $display("FAIL switches_pending: %0d pulses missing, required 0",
                  exp_load_q.size() + exp_change_q.size() + exp_mode_q.size());
         exp_load_q.delete(); exp_change_q.delete(); exp_mode_q.delete();
      end
   endtask

   task automatic test_reset_mid_press();
      logic [31:0] c0;
      c0 = cyc;
      load_raw = 1'b1;
      step(4);
      n_checks++;
      if (dbg_state[1:0] !== 2'd1) begin
         n_fail++;
         $display("FAIL mid_press_state: load state %0d, required 1", dbg_state[1:0]);
      end
      rst = 1'b1;
      step(1);
      n_checks++;
      if ({digit_load, digit_change, mode_change} !== 3'b000 || digit_choice !== 7'h00 ||
          device_choice !== 2'b00 || dbg_state !== 6'd0) begin
         n_fail++;
         $display("FAIL mid_press_reset: pulses %b digit %h device %b state %h, required all 0",
                  {digit_load, digit_change, mode_change}, digit_choice, device_choice, dbg_state);
      end
      rst = 1'b0;
      exp_load_q.push_back(c0 + 13);
      step(20);
      load_raw = 1'b0;
      step(15);
      n_checks++;
      if (exp_load_q.size() + exp_change_q.size() + exp_mode_q.size() != 0) begin
         n_fail++;
         $display("FAIL mid_press_pending: %0d pulses missing, required 0",
                  exp_load_q.size() + exp_change_q.size() + exp_mode_q.size());
         exp_load_q.delete(); exp_change_q.delete(); exp_mode_q.delete();
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] c0;
      c0 = cyc;
      load_raw = 1'b1; change_raw = 1'b1; mode_raw = 1'b1;
      exp_load_q.push_back(c0 + 8);
      exp_change_q.push_back(c0 + 8);
      exp_mode_q.push_back(c0 + 8);
      step(8);
      n_checks++;
      if ({digit_load, digit_change, mode_change} !== 3'b111) begin
         n_fail++;
         $display("FAIL simultaneous_pulses: got %b at edge %0d, required 111", {digit_load, digit_change, mode_change}, cyc);
      end
      step(2);
      load_raw = 1'b0; change_raw = 1'b0; mode_raw = 1'b0;
      step(30);
      n_checks++;
      if (exp_load_q.size() + exp_change_q.size() + exp_mode_q.size() != 0) begin
         n_fail++;
         $display("FAIL simultaneous_pending: %0d pulses missing, required 0",
                  exp_load_q.size() + exp_change_q.size() + exp_mode_q.size());
         exp_load_q.delete(); exp_change_q.delete(); exp_mode_q.delete();
      end
   endtask

   initial begin
      rst = 1'b1;
      load_raw = 1'b0; change_raw = 1'b0; mode_raw = 1'b0;
      digit_choice_raw = '0; device_choice_raw = '0;
      step(1);
      test_reset();
      test_clean_press();
      test_glitch();
      test_bounce();
      test_hold_repeat();
      test_back_to_back();
      test_switches();
      test_reset_mid_press();
      test_simultaneous();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
